// File: rtl/dmem_responder.sv
// Word-organised data RAM answering LSU requests after a fixed number of wait states.
// Request fields live in lsu_pkg; completions are single-cycle success pulses.
package lsu_pkg;
    typedef struct packed {
        logic        write_en;
        logic        read_en;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } lsu_to_mem_s;

    typedef struct packed {
        logic        w_success;
        logic        r_success;
        logic [31:0] data;
    } mem_to_lsu_s;
endpackage

module dmem_responder
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  lsu_to_mem_s lsu_to_mem_i,
    output mem_to_lsu_s mem_to_lsu_o
);
    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAST_CNT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           op_we_q;
    logic [AW-1:0]  idx_q;
    logic           oor_q;
    logic [31:0]    wdata_q;
    logic [3:0]     strb_q;
    logic           w_succ_q, r_succ_q;
    logic [31:0]    rdata_q;
    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           capture_s;
    logic           enter_resp_s;
    logic           eff_we_s;
    logic [AW-1:0]  eff_idx_s;
    logic           eff_oor_s;
    logic [31:0]    eff_wdata_s;
    logic [3:0]     eff_strb_s;
    logic [31:0]    rd_word_s;
    logic           addr_lsb_unused_s;

    // The LSU aligns accesses, so the byte offset carries no information here.
    assign addr_lsb_unused_s = ^lsu_to_mem_i.addr[1:0];

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lsu_to_mem_i.write_en || lsu_to_mem_i.read_en) begin
                    capture_s = 1'b1;
                    cnt_d     = 4'd0;
                    state_d   = (WAIT_CYCLES > 0) ? ST_BUSY : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states RESP is entered on the accepting edge, so bypass the request registers.
    always_comb begin
        enter_resp_s = (state_d == ST_RESP);
        if (capture_s) begin
            eff_we_s    = lsu_to_mem_i.write_en;
            eff_idx_s   = lsu_to_mem_i.addr[AW+1:2];
            eff_oor_s   = (lsu_to_mem_i.addr[31:2] >= DEPTH_LIM);
            eff_wdata_s = lsu_to_mem_i.data;
            eff_strb_s  = lsu_to_mem_i.strb;
        end else begin
            eff_we_s    = op_we_q;
            eff_idx_s   = idx_q;
            eff_oor_s   = oor_q;
            eff_wdata_s = wdata_q;
            eff_strb_s  = strb_q;
        end
        rd_word_s = eff_oor_s ? 32'h0000_0000 : mem_q[eff_idx_s];
    end

    // FSM state, counter and registered completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            w_succ_q <= 1'b0;
            r_succ_q <= 1'b0;
            rdata_q  <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_succ_q <= enter_resp_s && eff_we_s;
            r_succ_q <= enter_resp_s && !eff_we_s;
            if (enter_resp_s && !eff_we_s) begin
                rdata_q <= rd_word_s;
            end
        end
    end

    // Request registers load only when a request is accepted.
    always_ff @(posedge clk) begin
        if (capture_s && !rst) begin
            op_we_q <= lsu_to_mem_i.write_en;
            idx_q   <= lsu_to_mem_i.addr[AW+1:2];
            oor_q   <= (lsu_to_mem_i.addr[31:2] >= DEPTH_LIM);
            wdata_q <= lsu_to_mem_i.data;
            strb_q  <= lsu_to_mem_i.strb;
        end
    end

    // Byte-strobed RAM commit; contents survive reset.
    always_ff @(posedge clk) begin
        if (enter_resp_s && eff_we_s && !eff_oor_s && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_strb_s[i]) begin
                    mem_q[eff_idx_s][8*i +: 8] <= eff_wdata_s[8*i +: 8];
                end
            end
        end
    end

    assign mem_to_lsu_o.w_success = w_succ_q;
    assign mem_to_lsu_o.r_success = r_succ_q;
    assign mem_to_lsu_o.data      = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder, three instances with different wait states.
module tb_dmem_responder;
    import lsu_pkg::*;

    localparam int WAIT_K  [3] = '{1, 0, 3};
    localparam int DEPTH_K [3] = '{1024, 16, 8};

    logic        clk;
    logic [2:0]  rst_s;
    lsu_to_mem_s req [3];
    mem_to_lsu_s rsp [3];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m   [3][1024];
    logic [3:0]  vld_m   [3][1024];
    logic [31:0] rd_m    [3];
    logic [31:0] rdmask_m[3];

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst_s[0]), .lsu_to_mem_i(req[0]), .mem_to_lsu_o(rsp[0]));
    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst_s[1]), .lsu_to_mem_i(req[1]), .mem_to_lsu_o(rsp[1]));
    dmem_responder #(.DEPTH_WORDS(8), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst_s[2]), .lsu_to_mem_i(req[2]), .mem_to_lsu_o(rsp[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // One full transaction on instance k, starting in IDLE just after a clock edge.
    task automatic txn(input int k, input bit we, input bit re, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input string tag);
        int  n = 0;
        bit  seen = 0;
        bit  oor;
        int  idx;
        logic [31:0] obs_data;
        bit  obs_w, obs_r;
        req[k] = '{write_en: we, read_en: re, addr: addr, data: data, strb: strb};
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (rsp[k].w_success || rsp[k].r_success) seen = 1;
        end
        obs_w    = rsp[k].w_success;
        obs_r    = rsp[k].r_success;
        obs_data = rsp[k].data;
        req[k]   = '0;
        oor = (addr[31:2] >= 30'(DEPTH_K[k]));
        idx = oor ? 0 : int'(addr[31:2]);
        chk({tag, "_latency"}, 32'(n), 32'(WAIT_K[k] + 1));
        chk({tag, "_wsucc"}, {31'd0, obs_w}, {31'd0, we});
        chk({tag, "_rsucc"}, {31'd0, obs_r}, {31'd0, !we});
        if (we) begin
            if (!oor) begin
                for (int i = 0; i < 4; i++) begin
                    if (strb[i]) begin
                        mem_m[k][idx][8*i +: 8] = data[8*i +: 8];
                        vld_m[k][idx][i] = 1'b1;
                    end
                end
            end
        end else begin
            rd_m[k]     = oor ? 32'h0 : mem_m[k][idx];
            rdmask_m[k] = oor ? 32'hFFFF_FFFF : lane_mask(vld_m[k][idx]);
        end
        chk({tag, "_data"}, obs_data & rdmask_m[k], rd_m[k] & rdmask_m[k]);
        @(posedge clk); #1;
        chk({tag, "_pulse_end"}, {30'd0, rsp[k].w_success, rsp[k].r_success}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        bit          we, re;
        for (int k = 0; k < 3; k++) begin
            req[k]      = '0;
            rd_m[k]     = 32'h0;
            rdmask_m[k] = 32'hFFFF_FFFF;
            for (int w = 0; w < 1024; w++) vld_m[k][w] = 4'h0;
        end
        rst_s = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        rst_s = 3'b000;
        for (int k = 0; k < 3; k++) begin
            chk("reset_out", {rsp[k].w_success, rsp[k].r_success, rsp[k].data[29:0]}, 32'd0);
            chk("reset_data_hi", {30'd0, rsp[k].data[31:30]}, 32'd0);
        end

        // Read after write, one wait state.
        txn(0, 1, 0, 32'h10, 32'hDEAD_BEEF, 4'hF, "raw_wr");
        txn(0, 0, 1, 32'h10, 32'h0, 4'h0, "raw_rd");
        chk("raw_const", rsp[0].data, 32'hDEAD_BEEF);

        // Byte strobes.
        txn(0, 1, 0, 32'h20, 32'h1122_3344, 4'hF, "strb_init");
        txn(0, 1, 0, 32'h20, 32'hAABB_CCDD, 4'b0101, "strb_wr");
        txn(0, 0, 1, 32'h20, 32'h0, 4'h0, "strb_rd");
        chk("strb_const", rsp[0].data, 32'h11BB_33DD);

        // Out of range, word 0 must survive.
        txn(0, 1, 0, 32'h0, 32'h7654_3210, 4'hF, "oor_w0");
        txn(0, 1, 0, 32'h1000, 32'hFFFF_FFFF, 4'hF, "oor_wr");
        txn(0, 0, 1, 32'h1000, 32'h0, 4'h0, "oor_rd");
        chk("oor_const", rsp[0].data, 32'h0);
        txn(0, 0, 1, 32'h0, 32'h0, 4'h0, "oor_word0");
        chk("oor_word0_const", rsp[0].data, 32'h7654_3210);

        // Simultaneous enables count as a write and leave the data output alone.
        txn(0, 1, 1, 32'h4, 32'h5A5A_5A5A, 4'hF, "both_en");
        chk("both_keep_const", rsp[0].data, 32'h7654_3210);
        txn(0, 0, 1, 32'h4, 32'h0, 4'h0, "both_rd");
        chk("both_rd_const", rsp[0].data, 32'h5A5A_5A5A);

        // Zero wait: held enable gives a pulse every second cycle.
        txn(1, 1, 0, 32'h4, 32'h0BAD_F00D, 4'hF, "hold_init");
        req[1] = '{write_en: 1'b0, read_en: 1'b1, addr: 32'h4, data: 32'h0, strb: 4'h0};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("hold_pulse", {31'd0, rsp[1].r_success}, {31'd0, ((i % 2) == 0)});
        end
        chk("hold_data", rsp[1].data, 32'h0BAD_F00D);
        req[1] = '0;
        rd_m[1] = 32'h0BAD_F00D;
        rdmask_m[1] = 32'hFFFF_FFFF;
        @(posedge clk); #1;

        // Reset during the second busy cycle discards the write.
        txn(2, 1, 0, 32'h8, 32'h0123_4567, 4'hF, "rst_init");
        req[2] = '{write_en: 1'b1, read_en: 1'b0, addr: 32'h8, data: 32'hCAFE_F00D, strb: 4'hF};
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_s[2] = 1'b1;
        @(posedge clk); #1;
        rst_s[2] = 1'b0;
        req[2]   = '0;
        chk("rst_mid_out", {30'd0, rsp[2].w_success, rsp[2].r_success}, 32'd0);
        chk("rst_mid_data", rsp[2].data, 32'h0);
        rd_m[2] = 32'h0;
        rdmask_m[2] = 32'hFFFF_FFFF;
        repeat (5) begin
            @(posedge clk); #1;
            chk("rst_no_pulse", {30'd0, rsp[2].w_success, rsp[2].r_success}, 32'd0);
        end
        txn(2, 0, 1, 32'h8, 32'h0, 4'h0, "rst_rd");
        chk("rst_rd_const", rsp[2].data, 32'h0123_4567);

        // Randomized traffic on all three instances.
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 80; t++) begin
                we = 1'($urandom_range(0, 1));
                re = we ? 1'($urandom_range(0, 1)) : 1'b1;
                if ($urandom_range(0, 9) == 0) begin
                    a = $urandom() | 32'h0001_0000;
                end else begin
                    a = {2'b00, 28'($urandom_range(0, DEPTH_K[k])), 2'($urandom_range(0, 3))};
                end
                d = $urandom();
                txn(k, we, re, a, d, 4'($urandom_range(0, 15)), "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
